// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - asynchronous SRAM target: byte-lane memory, programmable read latency, access counters
module sram_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    inout  wire  [15:0] SRAM_DQ,
    input  logic [18:0] SRAM_ADDR,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_LB_N,
    input  logic        SRAM_UB_N,
    input  logic        RamClk,
    input  logic        RamAdv,
    output logic [15:0] write_count,
    output logic [15:0] read_count,
    output logic        busy,
    output logic        mode_err
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [2:0] WAIT_LOAD = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ_DRIVE,
        WRITE_ACTIVE,
        WRITE_COMMIT
    } state_t;

    state_t state, state_n;
    logic [2:0] wait_cnt, wait_cnt_n;
    logic       rd_start;

    logic        ce_s1, oe_s1, we_s1, lb_s1, ub_s1, clk_s1, adv_s1;
    logic [18:0] addr_s1;
    logic [15:0] dq_s1;
    logic        ce_s2, oe_s2, we_s2;
    logic [18:0] addr_s2;

    logic [15:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] rd_idx;
    logic [ADDR_BITS-1:0] wr_idx;
    logic [15:0]          wr_data;
    logic                 wr_lb_n, wr_ub_n;
    logic [15:0]          rd_word;
    logic                 addr_changed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ce_s1   <= 1'b1;
            oe_s1   <= 1'b1;
            we_s1   <= 1'b1;
            lb_s1   <= 1'b1;
            ub_s1   <= 1'b1;
            clk_s1  <= 1'b0;
            adv_s1  <= 1'b0;
            addr_s1 <= '0;
            dq_s1   <= '0;
            ce_s2   <= 1'b1;
            oe_s2   <= 1'b1;
            we_s2   <= 1'b1;
            addr_s2 <= '0;
        end else begin
            ce_s1   <= SRAM_CE_N;
            oe_s1   <= SRAM_OE_N;
            we_s1   <= SRAM_WE_N;
            lb_s1   <= SRAM_LB_N;
            ub_s1   <= SRAM_UB_N;
            clk_s1  <= RamClk;
            adv_s1  <= RamAdv;
            addr_s1 <= SRAM_ADDR;
            dq_s1   <= SRAM_DQ;
            ce_s2   <= ce_s1;
            oe_s2   <= oe_s1;
            we_s2   <= we_s1;
            addr_s2 <= addr_s1;
        end
    end

    // Only an address move between two consecutive read-cycle samples restarts the access.
    assign addr_changed = (addr_s1 != addr_s2) && !ce_s2 && !oe_s2 && we_s2;

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        rd_start   = 1'b0;
        case (state)
            IDLE: begin
                if (!ce_s1 && !we_s1) begin
                    state_n = WRITE_ACTIVE;
                end else if (!ce_s1 && !oe_s1) begin
                    rd_start = 1'b1;
                end
            end
            READ_WAIT, READ_DRIVE: begin
                if (ce_s1) begin
                    state_n = IDLE;
                end else if (!we_s1) begin
                    state_n = WRITE_ACTIVE;
                end else if (oe_s1) begin
                    state_n = IDLE;
                end else if (addr_changed) begin
                    rd_start = 1'b1;
                end else if (state == READ_WAIT) begin
                    if (wait_cnt == 3'd0) begin
                        state_n = READ_DRIVE;
                    end else begin
                        wait_cnt_n = wait_cnt - 3'd1;
                    end
                end
            end
            WRITE_ACTIVE: begin
                if (we_s1 || ce_s1) begin
                    state_n = WRITE_COMMIT;
                end
            end
            WRITE_COMMIT: state_n = IDLE;
            default:      state_n = IDLE;
        endcase
        if (rd_start) begin
            state_n    = (READ_LATENCY > 1) ? READ_WAIT : READ_DRIVE;
            wait_cnt_n = WAIT_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rd_idx      <= '0;
            write_count <= '0;
            read_count  <= '0;
            mode_err    <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            if (rd_start) begin
                rd_idx <= addr_s1[ADDR_BITS-1:0];
            end
            if (rd_start && read_count != 16'hFFFF) begin
                read_count <= read_count + 16'd1;
            end
            if (state == WRITE_COMMIT && write_count != 16'hFFFF) begin
                write_count <= write_count + 16'd1;
            end
            if (!ce_s1 && (clk_s1 || adv_s1)) begin
                mode_err <= 1'b1;
            end
        end
    end

    // Array contents and write capture are deliberately outside reset so memory survives it.
    always_ff @(posedge clk) begin
        if (state == WRITE_ACTIVE) begin
            wr_idx  <= addr_s1[ADDR_BITS-1:0];
            wr_data <= dq_s1;
            wr_lb_n <= lb_s1;
            wr_ub_n <= ub_s1;
        end
        if (state == WRITE_COMMIT) begin
            if (!wr_lb_n) begin
                mem[wr_idx][7:0] <= wr_data[7:0];
            end
            if (!wr_ub_n) begin
                mem[wr_idx][15:8] <= wr_data[15:8];
            end
        end
    end

    assign rd_word = mem[rd_idx];
    assign busy    = (state != IDLE);

    assign SRAM_DQ[15:8] = (state == READ_DRIVE && !ub_s1) ? rd_word[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (state == READ_DRIVE && !lb_s1) ? rd_word[7:0]  : 8'hzz;

endmodule
